// File: rtl/self_clean_pkg.sv
// Purpose : shared types and defaults for the range-hood self-clean controller.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package self_clean_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        CLEAN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int HOLD_SECS_DEF  = 3;
    localparam int CLEAN_SECS_DEF = 180;
    localparam int HOLD_SECS_MAX  = 15;
    localparam int CLEAN_SECS_MAX = 5999;   // 99:59
    localparam int HOLD_W         = 4;      // holds up to HOLD_SECS_MAX

endpackage

// File: rtl/secs_to_mmss.sv
// Purpose : binary seconds -> BCD {M tens, M units, S tens, S units}, clamps at 99:59.
// Latency : combinational.
// Backpressure: none.
// Ports   : secs (W-bit binary seconds) in, bcd (16-bit MM:SS) out.
module secs_to_mmss #(
    parameter int W = 13
) (
    input  logic [W-1:0] secs,
    output logic [15:0]  bcd
);

    logic [31:0] secs_w;
    logic [31:0] min_w;
    logic [31:0] sec_w;
    logic [6:0]  mins;
    logic [6:0]  secs_lo;

    // Widen first so the /60 and %60 arithmetic is independent of W.
    assign secs_w = 32'(secs);

    always_comb begin
        min_w = secs_w / 32'd60;
        sec_w = secs_w % 32'd60;
        if (min_w > 32'd99) begin
            mins    = 7'd99;
            secs_lo = 7'd59;
        end else begin
            mins    = 7'(min_w);
            secs_lo = 7'(sec_w);
        end
        bcd = {4'(mins / 7'd10), 4'(mins % 7'd10),
               4'(secs_lo / 7'd10), 4'(secs_lo % 7'd10)};
    end

endmodule

// File: rtl/self_clean_ctrl.sv
// Purpose : hold-to-start self-clean timer: ARM hold, timed CLEAN, one-cycle DONE, abort.
// Latency : state 1 cycle after inputs; countdown one further cycle behind remaining.
// Backpressure: none; tick is a 1 Hz enable, all levels sampled every cycle.
// Ports   : clk, rst (sync, active-high), tick, is_on, start_clean, abort in;
//           cleaning, arming, done (Moore), aborted (pulse), countdown (BCD MM:SS) out.
module self_clean_ctrl
    import self_clean_pkg::*;
#(
    parameter int HOLD_SECS  = HOLD_SECS_DEF,
    parameter int CLEAN_SECS = CLEAN_SECS_DEF,
    parameter int TW         = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        is_on,
    input  logic        start_clean,
    input  logic        abort,
    output logic        cleaning,
    output logic        arming,
    output logic [15:0] countdown,
    output logic        done,
    output logic        aborted
);

    if (CLEAN_SECS < 1 || CLEAN_SECS > CLEAN_SECS_MAX ||
        longint'(CLEAN_SECS) > ((longint'(1) << TW) - 1)) begin : g_bad_clean_secs
        $error("self_clean_ctrl: CLEAN_SECS out of range for TW or above 5999");
    end
    if (HOLD_SECS < 1 || HOLD_SECS > HOLD_SECS_MAX) begin : g_bad_hold_secs
        $error("self_clean_ctrl: HOLD_SECS must be 1..15");
    end

    // Transition happens on the tick that would make the count equal HOLD_SECS.
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_SECS - 1);
    localparam logic [TW-1:0]     CLEAN_LOAD = TW'(CLEAN_SECS);

    state_t              state, state_nx;
    logic [HOLD_W-1:0]   hold_cnt, hold_nx;
    logic [TW-1:0]       remaining, rem_nx;
    logic                need_release, release_nx;
    logic                aborted_nx;
    logic [15:0]         mmss;

    secs_to_mmss #(.W(TW)) u_secs_to_mmss (
        .secs (remaining),
        .bcd  (mmss)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            remaining    <= '0;
            need_release <= 1'b0;
            aborted      <= 1'b0;
            countdown    <= 16'h0000;
        end else begin
            state        <= state_nx;
            hold_cnt     <= hold_nx;
            remaining    <= rem_nx;
            need_release <= release_nx;
            aborted      <= aborted_nx;
            countdown    <= (state == CLEAN || state == DONE) ? mmss : 16'h0000;
        end
    end

    always_comb begin
        state_nx   = state;
        hold_nx    = hold_cnt;
        rem_nx     = remaining;
        aborted_nx = 1'b0;

        case (state)
            IDLE: begin
                if (is_on && start_clean && !need_release) begin
                    state_nx = ARM;
                    hold_nx  = '0;
                end
            end
            ARM: begin
                // Releasing the button or powering off beats a coincident tick.
                if (!start_clean || !is_on) begin
                    state_nx = IDLE;
                end else if (tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_nx = CLEAN;
                        hold_nx  = '0;
                        rem_nx   = CLEAN_LOAD;
                    end else begin
                        hold_nx = hold_cnt + 1'b1;
                    end
                end
            end
            CLEAN: begin
                // Cancel wins over the final tick, so no done on that cycle.
                if (abort || !is_on) begin
                    state_nx   = IDLE;
                    rem_nx     = '0;
                    aborted_nx = 1'b1;
                end else if (tick && remaining != '0) begin
                    rem_nx = remaining - 1'b1;
                    if (remaining == TW'(1)) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // A button still held when the cycle finishes must be let go before the
    // next arm; a low level during DONE already counts as the release.
    always_comb begin
        if (state == DONE) begin
            release_nx = start_clean;
        end else begin
            release_nx = need_release && start_clean;
        end
    end

    assign cleaning = (state == CLEAN);
    assign arming   = (state == ARM);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_self_clean_ctrl.sv
// Purpose : self-checking bench for self_clean_ctrl against a seconds-level model.
// Latency : n/a.
// Backpressure: n/a.
module tb_self_clean_ctrl;

    localparam int HOLD  = 3;
    localparam int CSECS = 180;
    localparam int TWID  = 13;

    localparam int M_IDLE  = 0;
    localparam int M_ARM   = 1;
    localparam int M_CLEAN = 2;
    localparam int M_DONE  = 3;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        is_on;
    logic        start_clean;
    logic        abort;
    logic        cleaning;
    logic        arming;
    logic [15:0] countdown;
    logic        done;
    logic        aborted;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_clean = 0;
    int cnt_done  = 0;
    int cnt_abort = 0;

    // reference model state
    int          md = M_IDLE;
    int          held = 0;
    int          left = 0;
    bit          must_rel = 1'b0;
    bit          was_done = 1'b0;
    bit          model_live = 1'b0;
    logic [15:0] e_cd = 16'h0000;
    logic        e_ab = 1'b0;

    self_clean_ctrl #(
        .HOLD_SECS  (HOLD),
        .CLEAN_SECS (CSECS),
        .TW         (TWID)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .is_on       (is_on),
        .start_clean (start_clean),
        .abort       (abort),
        .cleaning    (cleaning),
        .arming      (arming),
        .countdown   (countdown),
        .done        (done),
        .aborted     (aborted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] mmss(input int s);
        int m;
        int r;
        m = s / 60;
        r = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Seconds-level model: advances one clock edge at a time on sampled inputs.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                md       = M_IDLE;
                held     = 0;
                left     = 0;
                must_rel = 1'b0;
                e_cd     = 16'h0000;
                e_ab     = 1'b0;
            end else begin
                was_done = (md == M_DONE);
                // display shows what was left during the previous cycle
                e_cd = (md == M_CLEAN || md == M_DONE) ? mmss(left) : 16'h0000;
                e_ab = 1'b0;
                if (md == M_IDLE) begin
                    if (is_on && start_clean && !must_rel) begin
                        md   = M_ARM;
                        held = 0;
                    end
                end else if (md == M_ARM) begin
                    if (!(is_on && start_clean)) begin
                        md = M_IDLE;
                    end else if (tick) begin
                        held = held + 1;
                        if (held == HOLD) begin
                            md   = M_CLEAN;
                            left = CSECS;
                        end
                    end
                end else if (md == M_CLEAN) begin
                    if (abort || !is_on) begin
                        md   = M_IDLE;
                        left = 0;
                        e_ab = 1'b1;
                    end else if (tick) begin
                        left = left - 1;
                        if (left == 0) md = M_DONE;
                    end
                end else begin
                    md = M_IDLE;
                end
                must_rel = was_done ? start_clean : (must_rel && start_clean);
            end
            model_live = 1'b1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_live) begin
                chk1("m_cleaning", cleaning, md == M_CLEAN);
                chk1("m_arming", arming, md == M_ARM);
                chk1("m_done", done, md == M_DONE);
                chk1("m_aborted", aborted, e_ab);
                chk16("m_countdown", countdown, e_cd);
                if (cleaning) cnt_clean++;
                if (done) cnt_done++;
                if (aborted) cnt_abort++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
        end
        tick = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; is_on = 1'b0; start_clean = 1'b0; abort = 1'b0;
        cyc();
        cyc();
        chk16("rst_countdown", countdown, 16'h0000);
        chk1("rst_cleaning", cleaning, 1'b0);
        chk1("rst_arming", arming, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_aborted", aborted, 1'b0);
        rst = 1'b0;
        cyc();

        // hold for three ticks then clean starts
        is_on = 1'b1; start_clean = 1'b1;
        cyc();
        chk1("arm_entry", arming, 1'b1);
        ticks(2);
        chk1("arm_after2", arming, 1'b1);
        chk1("no_clean_after2", cleaning, 1'b0);
        ticks(1);
        chk1("clean_entry", cleaning, 1'b1);
        chk1("arm_left", arming, 1'b0);
        cyc();
        chk16("cd_entry", countdown, 16'h0300);

        // power off at 75 s remaining
        ticks(105);
        cyc();
        chk16("cd_75", countdown, 16'h0115);
        is_on = 1'b0;
        cyc();
        chk1("off_aborted", aborted, 1'b1);
        chk1("off_cleaning", cleaning, 1'b0);
        cyc();
        chk1("off_pulse_once", aborted, 1'b0);
        chk16("off_cd_zero", countdown, 16'h0000);

        // release after two ticks, release coincides with a would-be third tick
        is_on = 1'b1; start_clean = 1'b0;
        cyc();
        cnt_clean = 0;
        start_clean = 1'b1;
        cyc();
        ticks(2);
        start_clean = 1'b0; tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk1("rel_arming", arming, 1'b0);
        repeat (3) cyc();
        chkn("rel_no_clean", cnt_clean, 0);

        // full run with button held throughout
        cnt_done = 0;
        start_clean = 1'b1;
        cyc();
        ticks(HOLD);
        cyc();
        chk16("full_cd_entry", countdown, 16'h0300);
        for (int i = 1; i <= CSECS; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            if (i == CSECS) begin
                chk1("fin_done", done, 1'b1);
                chk1("fin_cleaning", cleaning, 1'b0);
                chk16("fin_cd", countdown, 16'h0001);
            end
            cyc();
            if (i == 1) chk16("cd_0259", countdown, 16'h0259);
            if (i == CSECS - 1) chk16("cd_0001", countdown, 16'h0001);
            if (i == CSECS) begin
                chk1("fin_done_once", done, 1'b0);
                chk16("fin_cd_zero", countdown, 16'h0000);
            end
        end
        chkn("done_pulses", cnt_done, 1);

        // held button must not re-arm until released
        repeat (4) cyc();
        chk1("held_no_rearm", arming, 1'b0);
        start_clean = 1'b0;
        cyc();
        start_clean = 1'b1;
        cyc();
        chk1("rearm", arming, 1'b1);

        // abort together with the final tick
        cnt_done = 0; cnt_abort = 0;
        ticks(HOLD);
        ticks(CSECS - 1);
        abort = 1'b1; tick = 1'b1;
        cyc();
        abort = 1'b0; tick = 1'b0;
        chk1("ab_final_pulse", aborted, 1'b1);
        chk1("ab_final_done", done, 1'b0);
        start_clean = 1'b0;
        cyc();
        cyc();
        chkn("ab_done_cnt", cnt_done, 0);
        chkn("ab_pulse_cnt", cnt_abort, 1);

        // reset mid-clean, with abort and tick also asserted
        start_clean = 1'b1;
        cyc();
        ticks(HOLD);
        ticks(10);
        cnt_done = 0; cnt_abort = 0;
        rst = 1'b1; abort = 1'b1; tick = 1'b1;
        cyc();
        abort = 1'b0; tick = 1'b0;
        chk1("rstc_cleaning", cleaning, 1'b0);
        chk1("rstc_arming", arming, 1'b0);
        chk1("rstc_done", done, 1'b0);
        chk1("rstc_aborted", aborted, 1'b0);
        chk16("rstc_countdown", countdown, 16'h0000);
        rst = 1'b0; start_clean = 1'b0;
        repeat (3) cyc();
        chkn("rstc_no_done", cnt_done, 0);
        chkn("rstc_no_abort", cnt_abort, 0);

        // randomized traffic, checked every cycle by the model
        for (int c = 0; c < 4000; c++) begin
            rst   = ($urandom_range(999) == 0);
            tick  = 1'($urandom_range(1));
            is_on = ($urandom_range(999) != 0);
            if ($urandom_range(59) == 0) start_clean = ~start_clean;
            abort = ($urandom_range(799) == 0);
            cyc();
        end
        rst = 1'b0; tick = 1'b0; abort = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/self_clean_ctrl.md
SELF_CLEAN_CTRL -- requirements
Module: self_clean_ctrl

Interface
REQ-001 Parameter HOLD_SECS, default 3, ticks start_clean must stay high before cleaning starts (1..15).
REQ-002 Parameter CLEAN_SECS, default 180, cleaning duration in seconds (1..5999).
REQ-003 Parameter TW, default 13, width of the internal seconds counter; SHALL hold CLEAN_SECS.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 tick  in  1  one-cycle 1 Hz enable; all second-based timing advances only on tick.
REQ-007 is_on  in  1  hood powered-on level.
REQ-008 start_clean  in  1  clean-request button level (pre-debounced).
REQ-009 abort  in  1  user cancel request, level-sampled each cycle.
REQ-010 cleaning  out  1  high while in CLEAN.
REQ-011 arming  out  1  high while in ARM (hold in progress).
REQ-012 countdown  out  16  remaining time as BCD {M tens, M units, S tens, S units}.
REQ-013 done  out  1  one-cycle pulse on normal completion.
REQ-014 aborted  out  1  one-cycle pulse when CLEAN is cancelled.

Function
REQ-015 States SHALL be IDLE, ARM, CLEAN, DONE.
REQ-016 IDLE->ARM when is_on && start_clean; hold counter cleared on entry.
REQ-017 ARM: hold counter +1 on each tick with start_clean high; start_clean low or is_on low -> IDLE same cycle, takes priority over tick.
REQ-018 ARM->CLEAN on the cycle the hold counter would reach HOLD_SECS; remaining loaded with CLEAN_SECS on that cycle.
REQ-019 CLEAN: remaining -1 on each tick; remaining SHALL never underflow.
REQ-020 CLEAN->DONE on the tick that brings remaining from 1 to 0.
REQ-021 CLEAN->IDLE with one-cycle aborted pulse when abort or !is_on; abort wins over a simultaneous final tick (no done).
REQ-022 DONE lasts exactly one cycle, done=1 during it, then IDLE unconditionally.
REQ-023 Re-arm from IDLE after DONE requires start_clean low for at least one cycle (no auto-restart on held button).
REQ-024 countdown SHALL be a registered function of remaining, valid the cycle after remaining changes; max one cycle lag.
REQ-025 countdown = BCD of floor(remaining/60) and remaining mod 60; 0 outside CLEAN/DONE; 99:59 cap unreachable by parameter range.
REQ-026 cleaning, arming are Moore outputs decoded from registered state.
REQ-027 tick while in IDLE or DONE SHALL have no effect.

Reset
REQ-028 On rst: state=IDLE, counters=0, countdown=16'h0000, cleaning=arming=done=aborted=0.
REQ-029 rst mid-ARM or mid-CLEAN SHALL cancel silently: no done, no aborted pulse.
REQ-030 rst has priority over all other inputs, including tick.

Structure
REQ-031 Package self_clean_pkg SHALL hold the state enum and default HOLD_SECS/CLEAN_SECS constants.
REQ-032 Sub-module secs_to_mmss (binary seconds -> 16-bit BCD, combinational) SHALL be instantiated once, output registered in self_clean_ctrl.
REQ-033 Elaboration SHALL fail if CLEAN_SECS exceeds 2**TW-1 or 5999.

Verification
REQ-034 is_on=1, start_clean high 3 ticks -> arming 3 ticks, cleaning=1, countdown=16'h0300 one cycle after entry.
REQ-035 Release start_clean after 2 ticks -> IDLE, cleaning never asserts.
REQ-036 Full run CLEAN_SECS=180 -> countdown 03:00,02:59..00:01, done single pulse on 180th tick, cleaning drops same cycle.
REQ-037 abort asserted together with final tick -> aborted=1 one cycle, done stays 0.
REQ-038 is_on low at remaining=75 -> aborted pulse, countdown=0 next cycle; rst mid-CLEAN -> all outputs 0, no pulses.
REQ-039 start_clean held through DONE -> stays IDLE until start_clean low one cycle then high again.
